// File: rtl/frame_capture.sv
// frame_capture: captures one RGB565 camera frame into RGB444 frame-buffer writes.
// The camera inputs are treated as asynchronous data. They pass through two
// register stages and are edge-detected in the clk_25mhz domain.
// Optional build macro FRAME_CAPTURE_TEST_PATTERN_EN replaces the pixel data
// with a coordinate-derived pattern. Timing, addressing and FSM are unchanged.
module frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk_25mhz,
  input  logic        CPU_RESETN,
  input  logic        start,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [18:0] memory_write_addr,
  output logic [11:0] memory_write_data,
  output logic        memory_write_enable,
  output logic        busy,
  output logic        done
);

  // Counters are at least 10 bits wide so the pattern can always slice col[9:6] / row[8:5].
  localparam int CW = ($clog2(H_ACTIVE + 1) > 10) ? $clog2(H_ACTIVE + 1) : 10;
  localparam int RW = ($clog2(V_ACTIVE + 1) > 10) ? $clog2(V_ACTIVE + 1) : 10;

  localparam logic [CW-1:0] H_LIM  = CW'(H_ACTIVE);
  localparam logic [RW-1:0] V_LIM  = RW'(V_ACTIVE);
  localparam logic [18:0]   H_STEP = 19'(H_ACTIVE);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_FRAME = 2'd1;
  localparam logic [1:0] S_CAPTURE    = 2'd2;
  localparam logic [1:0] S_DONE       = 2'd3;

  // Synchronizer stages; *_s3 holds the previous second-stage value for edge detection.
  logic       pclk_s1_q,  pclk_s1_d;
  logic       pclk_s2_q,  pclk_s2_d;
  logic       pclk_s3_q,  pclk_s3_d;
  logic       vsync_s1_q, vsync_s1_d;
  logic       vsync_s2_q, vsync_s2_d;
  logic       vsync_s3_q, vsync_s3_d;
  logic       href_s1_q,  href_s1_d;
  logic       href_s2_q,  href_s2_d;
  logic       href_s3_q,  href_s3_d;
  logic [7:0] data_s1_q,  data_s1_d;
  logic [7:0] data_s2_q,  data_s2_d;

  // Capture state.
  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [18:0]   line_base_q, line_base_d;

  // Registered write port.
  logic          we_q, we_d;
  logic [18:0]   addr_q, addr_d;
  logic [11:0]   wdata_q, wdata_d;

  // Edge detections and pixel formatting.
  logic          pclk_evt;
  logic          vsync_fall;
  logic          vsync_rise;
  logic          href_fall;
  logic          in_window;
  logic [11:0]   pixel;

  // Edge detection on the synchronized camera signals.
  always_comb begin
    pclk_evt   = pclk_s2_q & ~pclk_s3_q;
    vsync_fall = vsync_s3_q & ~vsync_s2_q;
    vsync_rise = vsync_s2_q & ~vsync_s3_q;
    href_fall  = href_s3_q & ~href_s2_q;
    in_window  = (col_q < H_LIM) && (row_q < V_LIM);
  end

  // Pixel value presented on the strobe that follows a low-byte event.
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
  always_comb begin
    pixel = {col_q[9:6], col_q[9:6], row_q[8:5]};
  end
`else
  always_comb begin
    pixel = {hi_q[7:4], hi_q[2:0], data_s2_q[7], data_s2_q[4:1]};
  end
`endif

  // Next values for the synchronizer chains.
  always_comb begin
    pclk_s1_d  = cam_pclk;
    pclk_s2_d  = pclk_s1_q;
    pclk_s3_d  = pclk_s2_q;
    vsync_s1_d = cam_vsync;
    vsync_s2_d = vsync_s1_q;
    vsync_s3_d = vsync_s2_q;
    href_s1_d  = cam_href;
    href_s2_d  = href_s1_q;
    href_s3_d  = href_s2_q;
    data_s1_d  = cam_data;
    data_s2_d  = data_s1_q;
  end

  // FSM, counters and write-port next state.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    line_base_d = line_base_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WAIT_FRAME;
          row_d       = '0;
          col_d       = '0;
          phase_d     = 1'b0;
          line_base_d = '0;
        end
      end

      S_WAIT_FRAME: begin
        if (vsync_fall) begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (vsync_rise) begin
          // Frame end has priority, so a final pixel cannot strobe in DONE.
          state_d = S_DONE;
        end else if (href_fall) begin
          // line_base tracks row*H_ACTIVE by repeated addition instead of a multiply.
          if (row_q < V_LIM) begin
            row_d       = row_q + RW'(1);
            line_base_d = line_base_q + H_STEP;
          end
          col_d   = '0;
          phase_d = 1'b0;
        end else if (pclk_evt && href_s2_q) begin
          if (!phase_q) begin
            hi_d    = data_s2_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (in_window) begin
              we_d    = 1'b1;
              addr_d  = line_base_q + 19'(col_q);
              wdata_d = pixel;
            end
            if (col_q < H_LIM) begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_25mhz) begin
    if (!CPU_RESETN) begin
      pclk_s1_q   <= 1'b0;
      pclk_s2_q   <= 1'b0;
      pclk_s3_q   <= 1'b0;
      vsync_s1_q  <= 1'b0;
      vsync_s2_q  <= 1'b0;
      vsync_s3_q  <= 1'b0;
      href_s1_q   <= 1'b0;
      href_s2_q   <= 1'b0;
      href_s3_q   <= 1'b0;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      line_base_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      pclk_s1_q   <= pclk_s1_d;
      pclk_s2_q   <= pclk_s2_d;
      pclk_s3_q   <= pclk_s3_d;
      vsync_s1_q  <= vsync_s1_d;
      vsync_s2_q  <= vsync_s2_d;
      vsync_s3_q  <= vsync_s3_d;
      href_s1_q   <= href_s1_d;
      href_s2_q   <= href_s2_d;
      href_s3_q   <= href_s3_d;
      data_s1_q   <= data_s1_d;
      data_s2_q   <= data_s2_d;
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      line_base_q <= line_base_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Output mapping from registered state.
  always_comb begin
    memory_write_enable = we_q;
    memory_write_addr   = addr_q;
    memory_write_data   = wdata_q;
    busy                = (state_q == S_WAIT_FRAME) || (state_q == S_CAPTURE);
    done                = (state_q == S_DONE);
  end

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels stored per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, lines stored per frame.
REQ-003 SHALL have port clk_25mhz, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port CPU_RESETN, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to capture one frame.
REQ-006 SHALL have port cam_pclk, input, 1: camera pixel clock, sampled as data (frequency at most clk_25mhz/2).
REQ-007 SHALL have port cam_vsync, input, 1: camera frame sync, high between frames.
REQ-008 SHALL have port cam_href, input, 1: camera line-valid.
REQ-009 SHALL have port cam_data, input, 8: camera byte, RGB565 in two bytes per pixel, high byte first.
REQ-010 SHALL have port memory_write_addr, output, 19: frame-buffer write address.
REQ-011 SHALL have port memory_write_data, output, 12: RGB444 pixel {R,G,B}.
REQ-012 SHALL have port memory_write_enable, output, 1: one-cycle write strobe per stored pixel.
REQ-013 SHALL have port busy, output, 1: high in WAIT_FRAME or CAPTURE.
REQ-014 SHALL have port done, output, 1: high from frame end until next accepted start.

Function
REQ-015 SHALL pass cam_pclk, cam_vsync, cam_href and cam_data through two register stages; all decisions use the second-stage values.
REQ-016 SHALL detect a pclk event as synchronized pclk high while its previous-cycle value is low.
REQ-017 SHALL implement states IDLE, WAIT_FRAME, CAPTURE, DONE.
REQ-018 IDLE or DONE with start=1 SHALL go to WAIT_FRAME, clearing row, col and byte phase; done falls the same edge.
REQ-019 WAIT_FRAME SHALL go to CAPTURE on a synchronized vsync falling edge (1 then 0).
REQ-020 start in WAIT_FRAME or CAPTURE SHALL be ignored.
REQ-021 In CAPTURE, each pclk event with href=1 SHALL latch cam_data and toggle byte phase; phase 0 is the high byte, phase 1 the low byte.
REQ-022 On a phase-1 event, next cycle SHALL assert memory_write_enable with data {hi[7:4], hi[2:0],lo[7], lo[4:1]} (R5[4:1], G6[5:2], B5[4:1]).
REQ-023 memory_write_addr SHALL equal row*H_ACTIVE + col at the strobe cycle, computed without a multiplier (shift-add); col then increments.
REQ-024 Pixels with col >= H_ACTIVE or row >= V_ACTIVE SHALL not be written; counters SHALL saturate and not wrap.
REQ-025 A synchronized href falling edge SHALL increment row (saturating at V_ACTIVE), zero col and reset byte phase to 0, so a short or odd-byte line never corrupts the next line.
REQ-026 A synchronized vsync rising edge in CAPTURE SHALL go to DONE and set done, whether or not all V_ACTIVE lines arrived.
REQ-027 memory_write_enable SHALL never be high in IDLE, WAIT_FRAME or DONE, and never two consecutive cycles.
REQ-028 pclk events with href=0 SHALL be ignored.

Reset
REQ-029 CPU_RESETN=0 at a rising edge SHALL force state IDLE, row=0, col=0, phase=0, all sync stages 0, and memory_write_addr=0, memory_write_data=0, memory_write_enable=0, busy=0, done=0.
REQ-030 Reset mid-frame SHALL abort with no further writes; a fresh start is required after release.

Configuration
REQ-031 With macro FRAME_CAPTURE_TEST_PATTERN_EN defined, memory_write_data SHALL be {col[9:6], col[9:6], row[8:5]}, ignoring cam_data; timing, addressing and FSM are unchanged.
REQ-032 Without FRAME_CAPTURE_TEST_PATTERN_EN, data SHALL come from cam_data per REQ-022, and no pattern logic is synthesized.

Verification
REQ-033 Full frame: start, 640x480 camera model with bytes 0xF8,0x1F each pixel -> 307200 strobes, addr 0..307199 in order, data 0xF0F, done=1 after vsync rise.
REQ-034 Long line: one line carries 700 pixels -> only 640 strobes for that row; next row's first addr = row*640.
REQ-035 Odd-byte line: href falls after 3 bytes -> one strobe for that line; next line's first pixel decodes correctly from its high byte.
REQ-036 Mid-frame reset: CPU_RESETN low for 1 cycle at pixel 1000 -> no strobe afterwards, all outputs 0; start ignored while busy=1.
REQ-037 Test pattern (FRAME_CAPTURE_TEST_PATTERN_EN): pixel row 32, col 64 -> data 0x111, addr 20544.
